// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, complex word type and pack/unpack/saturate helpers
package fft_pkg;

  localparam int WIDTH      = 32;
  localparam int HALF_WIDTH = WIDTH / 2;
  localparam int Q_FRAC     = 15;
  localparam int T_W        = 18;
  localparam int Y_W        = 20;
  localparam int S_W        = Y_W - 2;

  typedef struct packed {
    logic signed [HALF_WIDTH-1:0] re;
    logic signed [HALF_WIDTH-1:0] im;
  } cplx_t;

  function automatic cplx_t cplx_unpack(input logic [WIDTH-1:0] word);
    cplx_t c;
    c.re = word[WIDTH-1:HALF_WIDTH];
    c.im = word[HALF_WIDTH-1:0];
    return c;
  endfunction

  function automatic logic [WIDTH-1:0] cplx_pack(input cplx_t c);
    return {c.re, c.im};
  endfunction

  // Returns {clipped, value}; clipped is set when the input left the 16-bit range.
  function automatic logic [HALF_WIDTH:0] sat16(input logic signed [S_W-1:0] v);
    if (v > S_W'(32767)) begin
      return {1'b1, 16'h7FFF};
    end else if (v < -S_W'(32768)) begin
      return {1'b1, 16'h8000};
    end
    return {1'b0, v[HALF_WIDTH-1:0]};
  endfunction

endpackage

// File: rtl/ibutterfly_4_pipe_if.sv
// rtl/ibutterfly_4_pipe_if.sv - sample/twiddle input and result output handshake bundle
interface ibutterfly_4_pipe_if;
  import fft_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, c, d;
  logic [WIDTH-1:0] w0, w1, w2, w3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out0, out1, out2, out3;
  logic             sat;

  modport slave (
    input  in_valid, a, b, c, d, w0, w1, w2, w3, out_ready,
    output in_ready, out_valid, out0, out1, out2, out3, sat
  );

  modport master (
    output in_valid, a, b, c, d, w0, w1, w2, w3, out_ready,
    input  in_ready, out_valid, out0, out1, out2, out3, sat
  );

endinterface

// File: rtl/cmul_conj.sv
// rtl/cmul_conj.sv - combinational x * conj(w) with Q1.15 twiddle, floor-shifted to 18 bits
module cmul_conj
  import fft_pkg::*;
(
  input  cplx_t                x,
  input  cplx_t                w,
  output logic signed [T_W-1:0] t_re,
  output logic signed [T_W-1:0] t_im
);

  logic signed [31:0] p_rr, p_ii, p_ir, p_ri;
  logic signed [32:0] s_re, s_im;

  always_comb begin
    p_rr = 32'(x.re) * 32'(w.re);
    p_ii = 32'(x.im) * 32'(w.im);
    p_ir = 32'(x.im) * 32'(w.re);
    p_ri = 32'(x.re) * 32'(w.im);
    // 33-bit sums so that (-1)*(-1) + (-1)*(-1) cannot wrap
    s_re = 33'(p_rr) + 33'(p_ii);
    s_im = 33'(p_ir) - 33'(p_ri);
    t_re = T_W'(s_re >>> Q_FRAC);
    t_im = T_W'(s_im >>> Q_FRAC);
  end

endmodule

// File: rtl/ibutterfly_4_pipe.sv
// rtl/ibutterfly_4_pipe.sv - 3-stage radix-4 inverse butterfly: conj-multiply, +j DFT, /4 and saturate
module ibutterfly_4_pipe
  import fft_pkg::*;
(
  input logic              clk,
  input logic              rst,
  ibutterfly_4_pipe_if.slave bus
);

  logic en;

  cplx_t                 x [4];
  cplx_t                 w [4];
  logic signed [T_W-1:0] tr [4];
  logic signed [T_W-1:0] ti [4];

  logic                  s1_valid_q, s1_valid_d;
  logic signed [T_W-1:0] t_re_q [4], t_re_d [4];
  logic signed [T_W-1:0] t_im_q [4], t_im_d [4];

  logic                  s2_valid_q, s2_valid_d;
  logic signed [Y_W-1:0] y_re_q [4], y_re_d [4];
  logic signed [Y_W-1:0] y_im_q [4], y_im_d [4];

  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_q [4], out_d [4];
  logic                  sat_q, sat_d;

  logic signed [Y_W-1:0] r [4];
  logic signed [Y_W-1:0] i [4];
  logic [HALF_WIDTH:0]   cl_re, cl_im;
  cplx_t                 o;

  // A single enable stalls the whole pipe whenever the output set is not taken.
  assign en = !out_valid_q || bus.out_ready;

  assign x[0] = cplx_unpack(bus.a);
  assign x[1] = cplx_unpack(bus.b);
  assign x[2] = cplx_unpack(bus.c);
  assign x[3] = cplx_unpack(bus.d);
  assign w[0] = cplx_unpack(bus.w0);
  assign w[1] = cplx_unpack(bus.w1);
  assign w[2] = cplx_unpack(bus.w2);
  assign w[3] = cplx_unpack(bus.w3);

  for (genvar g = 0; g < 4; g++) begin : g_cmul
    cmul_conj u_cmul (
      .x    (x[g]),
      .w    (w[g]),
      .t_re (tr[g]),
      .t_im (ti[g])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    t_re_d     = t_re_q;
    t_im_d     = t_im_q;
    if (en) begin
      s1_valid_d = bus.in_valid;
      t_re_d     = tr;
      t_im_d     = ti;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      r[k] = Y_W'(t_re_q[k]);
      i[k] = Y_W'(t_im_q[k]);
    end
    s2_valid_d = s2_valid_q;
    y_re_d     = y_re_q;
    y_im_d     = y_im_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      // j*(re + j*im) = -im + j*re
      y_re_d[0] = r[0] + r[1] + r[2] + r[3];
      y_im_d[0] = i[0] + i[1] + i[2] + i[3];
      y_re_d[1] = r[0] - i[1] - r[2] + i[3];
      y_im_d[1] = i[0] + r[1] - i[2] - r[3];
      y_re_d[2] = r[0] - r[1] + r[2] - r[3];
      y_im_d[2] = i[0] - i[1] + i[2] - i[3];
      y_re_d[3] = r[0] + i[1] - r[2] - i[3];
      y_im_d[3] = i[0] - r[1] - i[2] + r[3];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    sat_d       = sat_q;
    cl_re       = '0;
    cl_im       = '0;
    o           = '0;
    if (en) begin
      out_valid_d = s2_valid_q;
      sat_d       = 1'b0;
      for (int k = 0; k < 4; k++) begin
        cl_re    = sat16(S_W'(y_re_q[k] >>> 2));
        cl_im    = sat16(S_W'(y_im_q[k] >>> 2));
        o.re     = cl_re[HALF_WIDTH-1:0];
        o.im     = cl_im[HALF_WIDTH-1:0];
        out_d[k] = cplx_pack(o);
        sat_d    = sat_d | cl_re[HALF_WIDTH] | cl_im[HALF_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        out_q[k] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      out_q       <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    t_re_q <= t_re_d;
    t_im_q <= t_im_d;
    y_re_q <= y_re_d;
    y_im_q <= y_im_d;
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out0      = out_q[0];
  assign bus.out1      = out_q[1];
  assign bus.out2      = out_q[2];
  assign bus.out3      = out_q[3];
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_ibutterfly_4_pipe.sv
// tb/tb_ibutterfly_4_pipe.sv - directed vector table plus backpressure and mid-stream reset sequences
module tb_ibutterfly_4_pipe;

  typedef struct {
    string       name;
    logic [31:0] a, b, c, d;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] e0, e1, e2, e3;
    logic        esat;
  } vec_t;

  localparam logic [31:0] UNITW = 32'h7FFF_0000;
  localparam logic [31:0] W45   = 32'h5A82_A57E;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ibutterfly_4_pipe_if bus ();

  ibutterfly_4_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.a  = v.a;  bus.b  = v.b;  bus.c  = v.c;  bus.d  = v.d;
    bus.w0 = v.w0; bus.w1 = v.w1; bus.w2 = v.w2; bus.w3 = v.w3;
  endtask

  function automatic vec_t mk(input string nm, input logic [31:0] a, b, c, d, w0, w1, w2, w3,
                              e0, e1, e2, e3, input logic es);
    vec_t v;
    v.name = nm;
    v.a = a; v.b = b; v.c = c; v.d = d;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    v.esat = es;
    return v;
  endfunction

  // Unit twiddles, a.re = 4n+1 only: t0.re = 4n, so every output is (n, 0).
  function automatic vec_t stream_set(input int n);
    logic [31:0] e;
    e = {16'(n), 16'h0000};
    return mk("stream", {16'(4 * n + 1), 16'h0000}, 32'h0, 32'h0, 32'h0,
              UNITW, UNITW, UNITW, UNITW, e, e, e, e, 1'b0);
  endfunction

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, "_latency"}, 32'(lat), 32'd3);
    chk({v.name, "_out0"}, bus.out0, v.e0);
    chk({v.name, "_out1"}, bus.out1, v.e1);
    chk({v.name, "_out2"}, bus.out2, v.e2);
    chk({v.name, "_out3"}, bus.out3, v.e3);
    chk({v.name, "_sat"}, 32'(bus.sat), 32'(v.esat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   sent, rcv, cyc, stalls;
    vec_t sv;

    vecs[0] = mk("a_only", 32'h1000_0000, 32'h0, 32'h0, 32'h0, UNITW, UNITW, UNITW, UNITW,
                 32'h03FF_0000, 32'h03FF_0000, 32'h03FF_0000, 32'h03FF_0000, 1'b0);
    vecs[1] = mk("b_only", 32'h0, 32'h1000_0000, 32'h0, 32'h0, UNITW, UNITW, UNITW, UNITW,
                 32'h03FF_0000, 32'h0000_03FF, 32'hFC00_0000, 32'h0000_FC00, 1'b0);
    vecs[2] = mk("c_only", 32'h0, 32'h0, 32'h1000_0000, 32'h0, UNITW, UNITW, UNITW, UNITW,
                 32'h03FF_0000, 32'hFC00_0000, 32'h03FF_0000, 32'hFC00_0000, 1'b0);
    vecs[3] = mk("d_only", 32'h0, 32'h0, 32'h0, 32'h1000_0000, UNITW, UNITW, UNITW, UNITW,
                 32'h03FF_0000, 32'h0000_FC00, 32'hFC00_0000, 32'h0000_03FF, 1'b0);
    vecs[4] = mk("conj", 32'h1000_0000, 32'h0, 32'h0, 32'h0, 32'h0000_7FFF, 32'h0, 32'h0, 32'h0,
                 32'h0000_FC00, 32'h0000_FC00, 32'h0000_FC00, 32'h0000_FC00, 1'b0);
    vecs[5] = mk("sat_pos", 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF,
                 W45, W45, W45, W45, 32'h0000_7FFF, 32'h0, 32'h0, 32'h0, 1'b1);
    vecs[6] = mk("sat_neg", 32'h8000_8000, 32'h8000_8000, 32'h8000_8000, 32'h8000_8000,
                 W45, W45, W45, W45, 32'h0000_8000, 32'h0, 32'h0, 32'h0, 1'b1);

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out0", bus.out0, 32'h0);
    chk("reset_out3", bus.out3, 32'h0);
    chk("reset_sat", 32'(bus.sat), 32'd0);

    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k]);
    end

    sent = 0; rcv = 0; cyc = 0; stalls = 0;
    while (rcv < 6 && cyc < 60) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 6) begin
        sv = stream_set(100 * (sent + 1));
        drive(sv);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (!bus.in_ready) stalls++;
      if (bus.out_valid && bus.out_ready) begin
        sv = stream_set(100 * (rcv + 1));
        chk("bp_out0", bus.out0, sv.e0);
        chk("bp_out3", bus.out3, sv.e3);
        chk("bp_sat", 32'(bus.sat), 32'd0);
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    chk("bp_received", 32'(rcv), 32'd6);
    chk("bp_stall_cycles", 32'(stalls), 32'd5);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sv = stream_set(7 + k);
      drive(sv);
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out0", bus.out0, 32'h0);
    chk("midrst_out1", bus.out1, 32'h0);
    chk("midrst_out2", bus.out2, 32'h0);
    chk("midrst_out3", bus.out3, 32'h0);
    chk("midrst_sat", 32'(bus.sat), 32'd0);
    run_vec(stream_set(500));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
